// File: rtl/matvec_mac_seq.sv
// matvec_mac_seq: N x N matrix times N-vector using one shared multiply-accumulate
// unit. Operands are captured on start. One product is computed per cycle in
// row-major order. Each row's dot product is written to c as soon as it completes.
// out_valid is raised with the done pulse and is held until the next accepted start.
module matvec_mac_seq #(
  parameter int N      = 4,
  parameter int DW     = 7,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active-low
  input  logic                 start,
  input  logic                 abort,
  input  logic [N*N*DW-1:0]    a_flat,
  input  logic [N*DW-1:0]      b_flat,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [N*ACC_W-1:0]   c_flat
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  // Parameter sanity: the accumulator must hold a full dot product without overflow
  generate
    if (N < 2) begin : g_bad_n
      $error("matvec_mac_seq: N must be at least 2");
    end
    if (ACC_W < 2 * DW + $clog2(N)) begin : g_bad_accw
      $error("matvec_mac_seq: ACC_W too narrow for 2*DW + clog2(N)");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          row_q, row_d;
  logic [IW-1:0]          col_q, col_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [N*N*DW-1:0]      a_q, a_d;
  logic [N*DW-1:0]        b_q, b_d;
  logic [ACC_W-1:0]       c_q [N];
  logic [ACC_W-1:0]       c_d [N];
  logic                   out_valid_q, out_valid_d;

  logic [DW-1:0]          a_el;
  logic [DW-1:0]          b_el;
  logic [ACC_W-1:0]       a_ext;
  logic [ACC_W-1:0]       b_ext;
  logic [ACC_W-1:0]       prod;

  // Select the current matrix element a[row][col] and vector element b[col]
  always_comb begin
    a_el = a_q[(int'(row_q) * N + int'(col_q)) * DW +: DW];
    b_el = b_q[int'(col_q) * DW +: DW];
  end

  // Widen operands to the accumulator width. The low ACC_W bits of a two's-complement
  // product are correct when both operands are sign-extended first.
  generate
    if (SIGNED != 0) begin : g_sext
      assign a_ext = {{(ACC_W - DW){a_el[DW-1]}}, a_el};
      assign b_ext = {{(ACC_W - DW){b_el[DW-1]}}, b_el};
    end else begin : g_zext
      assign a_ext = {{(ACC_W - DW){1'b0}}, a_el};
      assign b_ext = {{(ACC_W - DW){1'b0}}, b_el};
    end
  endgenerate

  assign prod = a_ext * b_ext;

  // Next-state logic: capture on start, step the MAC once per cycle in RUN, and stop on abort
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        // start takes priority over a simultaneous abort here (abort is meaningless in IDLE)
        if (start) begin
          state_d     = S_RUN;
          a_d         = a_flat;
          b_d         = b_flat;
          row_d       = '0;
          col_d       = '0;
          acc_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d     = S_IDLE;
          acc_d       = '0;
          row_d       = '0;
          col_d       = '0;
          out_valid_d = 1'b0;
        end else if (col_q != LAST) begin
          acc_d = acc_q + prod;
          col_d = col_q + 1'b1;
        end else begin
          c_d[row_q] = acc_q + prod;
          acc_d      = '0;
          col_d      = '0;
          if (row_q != LAST) begin
            row_d = row_q + 1'b1;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any run in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        c_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign out_valid = out_valid_q;

  // Flatten the result array onto the output bus
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cflat
      assign c_flat[gi*ACC_W +: ACC_W] = c_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_matvec_mac_seq.sv
// tb_matvec_mac_seq: drives an unsigned and a signed instance in lockstep with shared
// operands. A vector table is applied in a loop, and a scoreboard queue holds the
// expected results of each accepted run. Hand-written sequences cover abort and async reset.
module tb_matvec_mac_seq;
  localparam int N  = 4;
  localparam int DW = 7;
  localparam int AW = 18;

  typedef logic [N*AW-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [N*N*DW-1:0] a_flat = '0;
  logic [N*DW-1:0]   b_flat = '0;
  logic              busy_u, done_u, ov_u;
  logic              busy_s, done_s, ov_s;
  logic [N*AW-1:0]   c_u, c_s;

  always #5 clk = ~clk;

  matvec_mac_seq #(.N(N), .DW(DW), .ACC_W(AW), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy_u), .done(done_u), .out_valid(ov_u), .c_flat(c_u)
  );

  matvec_mac_seq #(.N(N), .DW(DW), .ACC_W(AW), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy_s), .done(done_s), .out_valid(ov_s), .c_flat(c_s)
  );

  // mode: 0 plain, 1 zero the inputs mid-run, 2 pulse start mid-run, 3 abort together with start
  typedef struct {
    logic [N*N*DW-1:0] a;
    logic [N*DW-1:0]   b;
    word_t             exp_u;
    word_t             exp_s;
    int                mode;
    string             name;
  } vec_t;

  typedef struct {
    word_t exp_u;
    word_t exp_s;
    string name;
  } sb_t;

  vec_t tv[6];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one vector. Call at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_vec(input vec_t v);
    sb_t s;
    sb_t got;
    int  lat;
    int  bcnt;
    int  extra;
    a_flat = v.a;
    b_flat = v.b;
    start  = 1'b1;
    abort  = (v.mode == 3);
    s.exp_u = v.exp_u;
    s.exp_s = v.exp_s;
    s.name  = v.name;
    sb_q.push_back(s);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check($sformatf("%s out_valid cleared on start", v.name), word_t'(ov_u), word_t'(0));
    lat  = 0;
    bcnt = 0;
    while (!done_u && lat < 40) begin
      if (busy_u) bcnt++;
      if (v.mode == 1 && lat == 3) begin
        a_flat = '0;
        b_flat = '0;
      end
      if (v.mode == 2 && lat == 5) start = 1'b1;
      if (v.mode == 2 && lat == 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s done latency", v.name), word_t'(lat), word_t'(16));
    check($sformatf("%s busy cycles", v.name), word_t'(bcnt), word_t'(16));
    check($sformatf("%s out_valid at done", v.name), word_t'({ov_u, ov_s, done_s}), word_t'(3'b111));
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check($sformatf("%s c unsigned", got.name), c_u, got.exp_u);
      check($sformatf("%s c signed", got.name), c_s, got.exp_s);
    end else begin
      check($sformatf("%s scoreboard empty", v.name), word_t'(1), word_t'(0));
    end
    @(negedge clk);
    check($sformatf("%s done single pulse", v.name), word_t'({done_u, busy_u}), word_t'(0));
    check($sformatf("%s out_valid held", v.name), word_t'(ov_u), word_t'(1));
    if (v.mode == 2) begin
      extra = 0;
      for (int k = 0; k < 20; k++) begin
        if (done_u || busy_u) extra++;
        @(negedge clk);
      end
      check($sformatf("%s no queued run", v.name), word_t'(extra), word_t'(0));
    end
    $display("run %s: lat=%0d c_u=%h c_s=%h", v.name, lat, c_u, c_s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*N*DW-1:0] a;
    logic [N*DW-1:0]   b;
    word_t             eu;
    word_t             es;
    int                cnt;

    // identity: A=I, b=[1,2,3,4]
    a = '0; b = '0; eu = '0;
    for (int i = 0; i < N; i++) begin
      a[(i*N+i)*DW +: DW] = DW'(1);
      b[i*DW +: DW]       = DW'(i + 1);
      eu[i*AW +: AW]      = AW'(i + 1);
    end
    tv[0].a = a; tv[0].b = b; tv[0].exp_u = eu; tv[0].exp_s = eu; tv[0].mode = 0; tv[0].name = "identity";

    // ramp: a[i][j]=4i+j, b=1s -> 6,22,38,54; inputs zeroed during the run
    a = '0; b = '0; eu = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) a[(i*N+j)*DW +: DW] = DW'(N*i + j);
      b[i*DW +: DW] = DW'(1);
    end
    eu[0*AW +: AW] = AW'(6);
    eu[1*AW +: AW] = AW'(22);
    eu[2*AW +: AW] = AW'(38);
    eu[3*AW +: AW] = AW'(54);
    tv[1].a = a; tv[1].b = b; tv[1].exp_u = eu; tv[1].exp_s = eu; tv[1].mode = 1; tv[1].name = "ramp";

    // all 127: unsigned 64516; signed -1*-1*4 = 4
    a = '1; b = '1; eu = '0; es = '0;
    for (int i = 0; i < N; i++) begin
      eu[i*AW +: AW] = AW'(64516);
      es[i*AW +: AW] = AW'(4);
    end
    tv[2].a = a; tv[2].b = b; tv[2].exp_u = eu; tv[2].exp_s = es; tv[2].mode = 0; tv[2].name = "max";

    // all 7'h40 (-64 signed): 16384 either way; start pulsed mid-run
    a = '0; b = '0; eu = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) a[(i*N+j)*DW +: DW] = DW'(7'h40);
      b[i*DW +: DW]  = DW'(7'h40);
      eu[i*AW +: AW] = AW'(16384);
    end
    tv[3].a = a; tv[3].b = b; tv[3].exp_u = eu; tv[3].exp_s = eu; tv[3].mode = 2; tv[3].name = "neg64";

    // row 0 all -1, b=1s: unsigned c0=508, signed c0=-4 (18'h3FFFC)
    a = '0; b = '0; eu = '0; es = '0;
    for (int j = 0; j < N; j++) begin
      a[j*DW +: DW] = DW'(7'h7F);
      b[j*DW +: DW] = DW'(1);
    end
    eu[0 +: AW] = AW'(508);
    es[0 +: AW] = 18'h3FFFC;
    tv[4].a = a; tv[4].b = b; tv[4].exp_u = eu; tv[4].exp_s = es; tv[4].mode = 0; tv[4].name = "row0_minus1";

    // identity again with abort asserted alongside start in IDLE: start must win
    tv[5] = tv[0];
    tv[5].mode = 3;
    tv[5].name = "start_with_abort";

    // reset state
    #12;
    check("reset outputs u", word_t'({busy_u, done_u, ov_u}), word_t'(0));
    check("reset c u", c_u, word_t'(0));
    check("reset outputs s", word_t'({busy_s, done_s, ov_s}), word_t'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // table loop; consecutive entries run back-to-back
    for (int t = 0; t < 6; t++) begin
      run_vec(tv[t]);
      if (t == 2) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check($sformatf("max out_valid idle %0d", k), word_t'(ov_u), word_t'(1));
        end
      end
    end

    // abort at cycle 5 of a run
    a_flat = tv[1].a;
    b_flat = tv[1].b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort outputs", word_t'({busy_u, done_u, ov_u}), word_t'(0));
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_u || busy_u || ov_u) cnt++;
      @(negedge clk);
    end
    check("abort no done", word_t'(cnt), word_t'(0));
    tv[1].mode = 0;
    tv[1].name = "ramp_after_abort";
    run_vec(tv[1]);

    // async reset between edges in the middle of a run
    a_flat = tv[0].a;
    b_flat = tv[0].b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async reset outputs u", word_t'({busy_u, done_u, ov_u}), word_t'(0));
    check("async reset c u", c_u, word_t'(0));
    check("async reset c s", c_s, word_t'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after reset idle", word_t'({busy_u, done_u, ov_u}), word_t'(0));
    tv[0].name = "identity_after_reset";
    run_vec(tv[0]);

    check("scoreboard drained", word_t'(sb_q.size()), word_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
